// File: rtl/imm_pack_if.sv
// Handshake bus for imm_pack: valid/ready input side carrying the value to encode,
// valid/ready output side carrying the packed field, overflow flag and counter.
interface imm_pack_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] num_in;
  logic        imm_src;
  logic        out_valid;
  logic        out_ready;
  logic [25:0] num_out;
  logic        ovf;
  logic [7:0]  ovf_count;

  modport master (
    output in_valid, num_in, imm_src, out_ready,
    input  in_ready, out_valid, num_out, ovf, ovf_count
  );

  modport slave (
    input  in_valid, num_in, imm_src, out_ready,
    output in_ready, out_valid, num_out, ovf, ovf_count
  );
endinterface

// File: rtl/imm_pack.sv
// Two-stage immediate packer: encodes a signed 32-bit value into a 16- or 26-bit field.
// Define IMM_PACK_SAT_EN to clamp non-fitting values; otherwise they truncate.
module imm_pack (
  input  logic       clk,
  input  logic       rst_n,
  imm_pack_if.slave  bus
);
  localparam int unsigned IN_W    = 32;
  localparam int unsigned OUT_W   = 26;
  localparam int unsigned F0_W    = 16;
  localparam int unsigned F1_W    = 26;
  localparam int unsigned CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [OUT_W-1:0] F0_MAX = OUT_W'(26'h0007FFF);
  localparam logic [OUT_W-1:0] F0_MIN = OUT_W'(26'h0008000);
  localparam logic [OUT_W-1:0] F1_MAX = OUT_W'(26'h1FFFFFF);
  localparam logic [OUT_W-1:0] F1_MIN = OUT_W'(26'h2000000);

  logic              s1_valid;
  logic [IN_W-1:0]   s1_num;
  logic              s1_src;
  logic              s2_valid;
  logic [OUT_W-1:0]  s2_num;
  logic              s2_ovf;
  logic [CNT_W-1:0]  ovf_cnt;

  logic              s2_xfer_c;
  logic              s1_adv_c;
  logic              in_acc_c;
  logic              fits_c;
  logic [OUT_W-1:0]  enc_c;

  // Handshake: S1 may move on when S2 is empty or draining this cycle.
  assign s2_xfer_c    = s2_valid & bus.out_ready;
  assign s1_adv_c     = s1_valid & (~s2_valid | bus.out_ready);
  assign bus.in_ready = rst_n & (~s1_valid | s1_adv_c);
  assign in_acc_c     = bus.in_valid & bus.in_ready;

  // Field encoder: value fits when all bits above the field's sign bit match it.
  always_comb begin
    fits_c = 1'b0;
    enc_c  = '0;
    if (!s1_src) begin
      fits_c = (&s1_num[IN_W-1:F0_W-1]) | ~(|s1_num[IN_W-1:F0_W-1]);
      enc_c  = OUT_W'(s1_num[F0_W-1:0]);
`ifdef IMM_PACK_SAT_EN
      if (!fits_c) enc_c = s1_num[IN_W-1] ? F0_MIN : F0_MAX;
`endif
    end else begin
      fits_c = (&s1_num[IN_W-1:F1_W-1]) | ~(|s1_num[IN_W-1:F1_W-1]);
      enc_c  = OUT_W'(s1_num[F1_W-1:0]);
`ifdef IMM_PACK_SAT_EN
      if (!fits_c) enc_c = s1_num[IN_W-1] ? F1_MIN : F1_MAX;
`endif
    end
  end

  // Pipeline registers and saturating overflow counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_num   <= '0;
      s1_src   <= 1'b0;
      s2_valid <= 1'b0;
      s2_num   <= '0;
      s2_ovf   <= 1'b0;
      ovf_cnt  <= '0;
    end else begin
      if (in_acc_c) begin
        s1_num <= bus.num_in;
        s1_src <= bus.imm_src;
      end
      if (in_acc_c) begin
        s1_valid <= 1'b1;
      end else if (s1_adv_c) begin
        s1_valid <= 1'b0;
      end
      if (s1_adv_c) begin
        s2_valid <= 1'b1;
        s2_num   <= enc_c;
        s2_ovf   <= ~fits_c;
      end else if (s2_xfer_c) begin
        s2_valid <= 1'b0;
      end
      if (s2_xfer_c && s2_ovf && (ovf_cnt != CNT_MAX)) begin
        ovf_cnt <= ovf_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.num_out   = s2_num;
  assign bus.ovf       = s2_ovf;
  assign bus.ovf_count = ovf_cnt;
endmodule

// File: tb/tb_imm_pack.sv
// Directed bench for imm_pack: latency, encoding in both modes, backpressure,
// overflow counter saturation and mid-flight reset; a monitor checks output order.
module tb_imm_pack;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  imm_pack_if bus();

  imm_pack dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [26:0] exp_q[$];
  logic [26:0] mon_e;
  logic [31:0] b2b_in [4];
  logic [25:0] b2b_ex [4];

`ifdef IMM_PACK_SAT_EN
  localparam logic [25:0] EX_8000     = 26'h0007FFF;
  localparam logic [25:0] EX_2000000  = 26'h1FFFFFF;
  localparam logic [25:0] EX_80000000 = 26'h0008000;
  localparam logic [25:0] EX_STREAM   = 26'h0007FFF;
`else
  localparam logic [25:0] EX_8000     = 26'h0008000;
  localparam logic [25:0] EX_2000000  = 26'h2000000;
  localparam logic [25:0] EX_80000000 = 26'h0000000;
  localparam logic [25:0] EX_STREAM   = 26'h0002345;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Every output transfer must match the next expected entry, in order.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("mon_num", 32'(bus.num_out), 32'(mon_e[25:0]));
        chk("mon_ovf", 32'(bus.ovf), 32'(mon_e[26]));
      end
    end
  end

  task automatic single(input string tag, input logic [31:0] n, input logic s,
                        input logic [25:0] en, input logic eo);
    int lat;
    tick;
    bus.in_valid  = 1'b1;
    bus.num_in    = n;
    bus.imm_src   = s;
    bus.out_ready = 1'b1;
    exp_q.push_back({eo, en});
    @(negedge clk);
    chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
    tick;
    bus.in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (bus.out_valid !== 1'b1 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd2);
    chk({tag, "_num"}, 32'(bus.num_out), 32'(en));
    chk({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
  endtask

  initial begin
    int idx;
    int acc;
    int cyc;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.num_in    = '0;
    bus.imm_src   = 1'b0;
    bus.out_ready = 1'b0;
    b2b_in = '{32'h00000011, 32'h00000022, 32'hFFFFFFFF, 32'h00007FFF};
    b2b_ex = '{26'h0000011, 26'h0000022, 26'h000FFFF, 26'h0007FFF};

    // Reset state
    repeat (2) tick;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_num_out", 32'(bus.num_out), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    chk("rst_ovf_count", 32'(bus.ovf_count), 32'd0);
    tick;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Encoding in both modes, fitting and boundary values
    single("m0_7fff", 32'h00007FFF, 1'b0, 26'h0007FFF, 1'b0);
    single("m1_min", 32'hFE000000, 1'b1, 26'h2000000, 1'b0);
    single("m1_max", 32'h01FFFFFF, 1'b1, 26'h1FFFFFF, 1'b0);
    single("m0_neg", 32'hFFFF8000, 1'b0, 26'h0008000, 1'b0);
    single("m1_mid", 32'h00012345, 1'b1, 26'h0012345, 1'b0);
    single("m0_8000", 32'h00008000, 1'b0, EX_8000, 1'b1);
    tick;
    @(negedge clk);
    chk("ovf_count_1", 32'(bus.ovf_count), 32'd1);
    single("m1_ovf", 32'h02000000, 1'b1, EX_2000000, 1'b1);
    single("m0_negovf", 32'h80000000, 1'b0, EX_80000000, 1'b1);
    tick;
    @(negedge clk);
    chk("ovf_count_3", 32'(bus.ovf_count), 32'd3);

    // Back-to-back inputs with a 3-cycle output stall
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, b2b_ex[i]});
    idx = 0;
    for (int c = 0; c < 15; c++) begin
      tick;
      bus.out_ready = (c < 2 || c >= 5);
      bus.in_valid  = (idx < 4);
      bus.num_in    = (idx < 4) ? b2b_in[idx] : 32'd0;
      bus.imm_src   = 1'b0;
      @(negedge clk);
      if (c == 2) begin
        chk("b2b_in_ready_low", 32'(bus.in_ready), 32'd0);
        chk("b2b_accepted", 32'(idx), 32'd2);
      end
      if (c >= 2 && c < 5) begin
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_num", 32'(bus.num_out), 32'h11);
      end
      if (bus.in_valid && bus.in_ready) idx++;
    end
    bus.in_valid = 1'b0;
    chk("b2b_drained", 32'(exp_q.size()), 32'd0);

    // 300 overflowing values; counter must stick at 255
    tick;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 300; i++) exp_q.push_back({1'b1, EX_STREAM});
    acc = 0;
    cyc = 0;
    while (acc < 300 && cyc < 1000) begin
      bus.in_valid = 1'b1;
      bus.num_in   = 32'h00012345;
      bus.imm_src  = 1'b0;
      @(negedge clk);
      if (bus.in_ready) acc++;
      tick;
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk("stream_accepted", 32'(acc), 32'd300);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("stream_drained", 32'(exp_q.size()), 32'd0);
    tick;
    @(negedge clk);
    chk("ovf_count_sat", 32'(bus.ovf_count), 32'd255);

    // Reset with both stages full discards them
    tick;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.num_in    = 32'h5;
    @(negedge clk);
    tick;
    bus.num_in = 32'h6;
    @(negedge clk);
    tick;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("full_out_valid", 32'(bus.out_valid), 32'd1);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    tick;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    tick;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_ovf_count", 32'(bus.ovf_count), 32'd0);
    chk("midrst_in_ready_hi", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick;
      @(negedge clk);
      chk("midrst_no_out", 32'(bus.out_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/imm_pack.md
IMM_PACK -- requirements
Module: imm_pack

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port: in_valid  input  1  input value presented.
REQ-004 SHALL have port: in_ready  output  1  packer can accept input this cycle.
REQ-005 SHALL have port: num_in  input  32  signed value to encode.
REQ-006 SHALL have port: imm_src  input  1  field select; 0 = 16-bit field, 1 = 26-bit field; sampled with num_in.
REQ-007 SHALL have port: out_valid  output  1  packed field available.
REQ-008 SHALL have port: out_ready  input  1  consumer accepts output this cycle.
REQ-009 SHALL have port: num_out  output  26  packed immediate field.
REQ-010 SHALL have port: ovf  output  1  num_out value not representable in selected field; qualified by out_valid.
REQ-011 SHALL have port: ovf_count  output  8  saturating count of accepted outputs with ovf=1.

Function
REQ-012 SHALL accept input when in_valid && in_ready; SHALL transfer output when out_valid && out_ready.
REQ-013 SHALL be a 2-stage pipeline: S1 captures num_in/imm_src; S2 holds encoded result; out_valid = S2 valid.
REQ-014 SHALL present result 2 cycles after acceptance when out_ready is held high; throughput 1 per cycle.
REQ-015 SHALL advance S1->S2 when S2 empty or S2 transferring in same cycle.
REQ-016 SHALL drive in_ready = !S1_valid || S1 advancing; combinational from out_ready permitted; no combinational path in_valid->out_valid.
REQ-017 SHALL hold num_out, ovf, out_valid stable while out_valid && !out_ready.
REQ-018 Mode imm_src=0: fits iff num_in[31:15] all equal; num_out[15:0] = encoded value, num_out[25:16] = 0.
REQ-019 Mode imm_src=1: fits iff num_in[31:25] all equal; num_out[25:0] = encoded value.
REQ-020 If fits: encoded value = low field bits of num_in, ovf=0.
REQ-021 If not fits: ovf=1; encoded value per Configuration.
REQ-022 SHALL increment ovf_count on each output transfer with ovf=1; SHALL saturate at 255, no wrap.
REQ-023 Simultaneous input accept and output transfer with both stages full SHALL lose no data and duplicate none.
REQ-024 Round-trip property: for fitting values, sign-extending num_out with same imm_src SHALL reproduce num_in.

Reset
REQ-025 On clk edge with rst_n=0: S1/S2 valid cleared, out_valid=0, ovf=0, num_out=0, ovf_count=0.
REQ-026 in_ready SHALL be 0 while rst_n=0 and 1 in first cycle after rst_n returns high.
REQ-027 Reset mid-operation SHALL discard in-flight values; no output transfer for them after reset.

Configuration
REQ-028 Macro IMM_PACK_SAT_EN defined: non-fitting value SHALL clamp to field max (0x7FFF / 0x1FFFFFF) if positive, field min (0x8000 / 0x2000000) if negative.
REQ-029 Macro IMM_PACK_SAT_EN undefined: non-fitting value SHALL truncate to low field bits; ovf and ovf_count behave identically in both builds.

Verification
REQ-030 Mode 0, num_in=0x00007FFF, out_ready=1 -> 2 cycles later num_out=0x0007FFF, ovf=0.
REQ-031 Mode 1, num_in=0xFE000000 -> num_out=0x2000000, ovf=0; num_in=0x01FFFFFF -> 0x1FFFFFF, ovf=0.
REQ-032 Mode 0, num_in=0x00008000 -> ovf=1; num_out=0x0007FFF with IMM_PACK_SAT_EN, 0x0008000 without; ovf_count=1.
REQ-033 Back-to-back 4 inputs, out_ready low 3 cycles from cycle 2 -> in_ready low after 2 accepted; all 4 emitted in order, no duplicates.
REQ-034 300 overflowing values streamed -> ovf_count stops at 255.
REQ-035 rst_n low 1 cycle with both stages full -> next cycle out_valid=0, ovf_count=0, in_ready=1.
